// File: rtl/alu_if.sv
// Operand/result bundle between the EX-stage control and the registered ALU.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic                 force_add;
  logic [WIDTH-1:0]     data_a;
  logic [WIDTH-1:0]     data_b;
  logic [5:0]           funct;
  logic [4:0]           shamt;
  logic [2*WIDTH-1:0]   hilo;
  logic [WIDTH-1:0]     data_out;
  logic                 is_zero;

  modport master (
    output force_add, data_a, data_b, funct, shamt, hilo,
    input  data_out, is_zero
  );

  modport slave (
    input  force_add, data_a, data_b, funct, shamt, hilo,
    output data_out, is_zero
  );
endinterface

// File: rtl/alu.sv
// Registered integer ALU for the EX stage: R-type funct decode or forced ADD,
// one-cycle latency on both the result and the A==B flag used by BEQ.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic  clka,
  input  logic  reset,
  alu_if.slave  bus
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [WIDTH-1:0] data_out_reg;
  logic             is_zero_reg;
  logic [WIDTH-1:0] result_next;

  // Shared shifter: left shifts reuse the right-shift stages on bit-reversed data.
  logic             shift_left;
  logic             shift_arith;
  logic             shift_var;
  logic [SW-1:0]    shift_amt;
  logic             shift_fill;
  logic [WIDTH-1:0] b_rev;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] stage [SW+1];
  logic [WIDTH-1:0] shr_out;
  logic [WIDTH-1:0] shl_out;

  assign shift_left  = (bus.funct == F_SLL) || (bus.funct == F_SLLV);
  assign shift_arith = (bus.funct == F_SRA);
  assign shift_var   = (bus.funct == F_SLLV) || (bus.funct == F_SRLV);
  assign shift_amt   = shift_var ? bus.data_a[SW-1:0] : bus.shamt[SW-1:0];
  assign shift_fill  = shift_arith & bus.data_b[WIDTH-1];
  assign shift_in    = shift_left ? b_rev : bus.data_b;
  assign stage[0]    = shift_in;
  assign shr_out     = stage[SW];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign b_rev[gi]   = bus.data_b[WIDTH-1-gi];
    assign shl_out[gi] = shr_out[WIDTH-1-gi];
  end

  for (genvar gi = 0; gi < SW; gi++) begin : g_shift
    assign stage[gi+1] = shift_amt[gi]
                       ? {{(2**gi){shift_fill}}, stage[gi][WIDTH-1:2**gi]}
                       : stage[gi];
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;
  logic             lt_unsigned;

  assign sum         = bus.data_a + bus.data_b;
  assign diff        = bus.data_a - bus.data_b;
  assign lt_signed   = $signed(bus.data_a) < $signed(bus.data_b);
  assign lt_unsigned = bus.data_a < bus.data_b;

  always_comb begin
    result_next = '0;
    if (bus.force_add) begin
      result_next = sum;
    end else begin
      case (bus.funct)
        F_SLL, F_SLLV:         result_next = shl_out;
        F_SRL, F_SRA, F_SRLV:  result_next = shr_out;
        F_MFHI:                result_next = bus.hilo[2*WIDTH-1:WIDTH];
        F_MFLO:                result_next = bus.hilo[WIDTH-1:0];
        F_ADD, F_ADDU:         result_next = sum;
        F_SUB, F_SUBU:         result_next = diff;
        F_AND:                 result_next = bus.data_a & bus.data_b;
        F_OR:                  result_next = bus.data_a | bus.data_b;
        F_XOR:                 result_next = bus.data_a ^ bus.data_b;
        F_NOR:                 result_next = ~(bus.data_a | bus.data_b);
        F_SLT:                 result_next = {{(WIDTH-1){1'b0}}, lt_signed};
        F_SLTU:                result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
        default:               result_next = '0;
      endcase
    end
  end

  // The equality flag ignores the opcode so BEQ can compare while force_add is high.
  always_ff @(posedge clka) begin
    if (reset) begin
      data_out_reg <= '0;
      is_zero_reg  <= 1'b0;
    end else begin
      data_out_reg <= result_next;
      is_zero_reg  <= (bus.data_a == bus.data_b);
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.is_zero  = is_zero_reg;
endmodule

// File: tb/tb_alu.sv
// Directed and randomized checks of the registered ALU against a plain
// arithmetic reference of the instruction set.
module tb_alu;
  logic clka;
  logic reset;
  int   compared;
  int   mismatched;

  alu_if bus ();

  alu dut (
    .clka  (clka),
    .reset (reset),
    .bus   (bus)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] ref_alu(input logic fa, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] f,
                                          input logic [4:0] sh, input logic [63:0] hl);
    int unsigned va;
    va = a % 32;
    if (fa) return a + b;
    case (f)
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: return $unsigned($signed(b) >>> sh);
      6'h04: return b << va;
      6'h06: return b >> va;
      6'h10: return hl[63:32];
      6'h12: return hl[31:0];
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs_out, input logic obs_z,
                       input logic [31:0] exp_out, input logic exp_z);
    compared++;
    assert (obs_out === exp_out) else begin
      mismatched++;
      $error("FAIL %s data_out: got %h expected %h", tag, obs_out, exp_out);
    end
    compared++;
    assert (obs_z === exp_z) else begin
      mismatched++;
      $error("FAIL %s is_zero: got %b expected %b", tag, obs_z, exp_z);
    end
  endtask

  // One operation per cycle: drive on the falling edge, check just after the next rise.
  task automatic step(input string tag, input logic fa, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] f, input logic [4:0] sh,
                      input logic [63:0] hl);
    logic [31:0] exp_out;
    logic        exp_z;
    @(negedge clka);
    bus.force_add = fa;
    bus.data_a    = a;
    bus.data_b    = b;
    bus.funct     = f;
    bus.shamt     = sh;
    bus.hilo      = hl;
    exp_out = ref_alu(fa, a, b, f, sh, hl);
    exp_z   = (a == b);
    @(posedge clka);
    #1;
    $display("step %-10s fa=%b f=%h sh=%0d a=%h b=%h -> out=%h z=%b", tag, fa, f, sh, a, b,
             bus.data_out, bus.is_zero);
    check(tag, bus.data_out, bus.is_zero, exp_out, exp_z);
  endtask

  logic [5:0]  valid_f [17];
  logic [5:0]  rf;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    compared   = 0;
    mismatched = 0;
    valid_f = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h10, 6'h12, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    reset         = 1'b1;
    bus.force_add = 1'b0;
    bus.data_a    = 32'h3;
    bus.data_b    = 32'h3;
    bus.funct     = 6'h20;
    bus.shamt     = 5'd0;
    bus.hilo      = 64'h0;
    repeat (3) @(posedge clka);
    #1;
    $display("reset held: out=%h z=%b", bus.data_out, bus.is_zero);
    check("reset", bus.data_out, bus.is_zero, 32'h0, 1'b0);

    @(negedge clka);
    reset = 1'b0;
    step("add", 1'b0, 32'd5, 32'd7, 6'h20, 5'd0, 64'h0);

    // Reset asserted mid-stream must override a live computation.
    @(negedge clka);
    reset         = 1'b1;
    bus.data_a    = 32'h1234;
    bus.data_b    = 32'h1234;
    bus.funct     = 6'h20;
    @(posedge clka);
    #1;
    $display("reset midrun: out=%h z=%b", bus.data_out, bus.is_zero);
    check("reset_mid", bus.data_out, bus.is_zero, 32'h0, 1'b0);
    @(negedge clka);
    reset = 1'b0;

    step("nop",      1'b0, 32'h0,        32'h0,        6'h00, 5'd0,  64'h0);
    step("add",      1'b0, 32'd5,        32'd7,        6'h20, 5'd0,  64'h0);
    step("sub",      1'b0, 32'h9,        32'hA,        6'h22, 5'd0,  64'h0);
    step("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h1,        6'h20, 5'd0,  64'h0);
    step("srl",      1'b0, 32'h0,        32'h10,       6'h02, 5'd2,  64'h0);
    step("sra",      1'b0, 32'h0,        32'h80000000, 6'h03, 5'd4,  64'h0);
    step("sll31",    1'b0, 32'h0,        32'h1,        6'h00, 5'd31, 64'h0);
    step("sll0",     1'b0, 32'h0,        32'hA5A5F00F, 6'h00, 5'd0,  64'h0);
    step("sllv",     1'b0, 32'hFFFFFFE3, 32'h00000081, 6'h04, 5'd9,  64'h0);
    step("srlv",     1'b0, 32'h00000024, 32'hF0000000, 6'h06, 5'd0,  64'h0);
    step("fadd",     1'b1, 32'h100,      32'hFFFFFFFC, 6'h22, 5'd7,  64'h0);
    step("beq_eq",   1'b1, 32'h1234,     32'h1234,     6'h00, 5'd0,  64'h0);
    step("beq_ne",   1'b1, 32'h1,        32'h2,        6'h00, 5'd0,  64'h0);
    step("mfhi",     1'b0, 32'h0,        32'h0,        6'h10, 5'd0,  64'h00000002_00000003);
    step("mflo",     1'b0, 32'h0,        32'h0,        6'h12, 5'd0,  64'h00000002_00000003);
    step("multu",    1'b0, 32'h5,        32'h6,        6'h19, 5'd0,  64'h00000002_00000003);
    step("slt",      1'b0, 32'hFFFFFFFF, 32'h1,        6'h2A, 5'd0,  64'h0);
    step("sltu",     1'b0, 32'hFFFFFFFF, 32'h1,        6'h2B, 5'd0,  64'h0);
    step("nor",      1'b0, 32'h0F0F0000, 32'h00FF00FF, 6'h27, 5'd0,  64'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rf = 6'($urandom_range(0, 63));
      else rf = valid_f[$urandom_range(0, 16)];
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      step("rand", ($urandom_range(0, 5) == 0), ra, rb, rf, 5'($urandom_range(0, 31)),
           {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
